charge_rate_controller: RTL and testbench
=========================================

CHARGE_RATE_CONTROLLER -- requirements
Module: charge_rate_controller

Interface
REQ-001 Parameter RAMP_STEP, default 16'd32: maximum setpoint increase per clock.
REQ-002 Parameter STABLE_CYCLES, default 256: consecutive GRID_NORMAL cycles required to leave DERATE.
REQ-003 Parameter HOLDOFF_CYCLES, default 1024: consecutive non-critical cycles required to leave FAULT.
REQ-004 Parameter V_START_ADC, default 16'd2800: minimum measured_voltage for starting a charge from IDLE.
REQ-005 Port clk, input, 1: single system clock, rising edge.
REQ-006 Port reset_n, input, 1: reset, asynchronous, active-low.
REQ-007 Port grid_state, input, grid_state_t: classification from grid_classifier.
REQ-008 Port measured_voltage, input, 16: filtered grid voltage from grid_classifier.
REQ-009 Port ev_connected, input, 1: vehicle plugged in.
REQ-010 Port charge_request, input, 1: vehicle requests charge.
REQ-011 Port current_request, input, 16: requested charge current, ADC units.
REQ-012 Port charge_setpoint, output, 16: registered current setpoint to the power stage.
REQ-013 Port charger_enable, output, 1: registered power stage enable.
REQ-014 Port charge_state, output, charge_state_t: registered FSM state.
REQ-015 Port fault_count, output, 8: saturating count of FAULT entries.

Function
REQ-016 FSM states SHALL be IDLE, RAMP, CHARGE, DERATE, FAULT; all outputs registered, one-cycle latency from input to output.
REQ-017 Target SHALL be current_request in GRID_NORMAL, current_request>>1 in GRID_UNSTABLE, 0 in GRID_CRITICAL.
REQ-018 IDLE -> RAMP when ev_connected & charge_request & measured_voltage >= V_START_ADC & grid_state == GRID_NORMAL.
REQ-019 RAMP: setpoint += min(RAMP_STEP, target - setpoint), sum computed 17-bit, never exceeding target or 16'hFFFF; -> CHARGE on the cycle the setpoint equals target.
REQ-020 CHARGE: setpoint tracks target, increases limited to RAMP_STEP/cycle, decreases applied in one cycle.
REQ-021 RAMP or CHARGE with GRID_UNSTABLE -> DERATE; setpoint drops to current_request>>1 on that same edge if above it.
REQ-022 DERATE: stable counter counts consecutive GRID_NORMAL cycles, clears on any GRID_UNSTABLE; at STABLE_CYCLES -> RAMP.
REQ-023 Any state with GRID_CRITICAL -> FAULT on the next edge; setpoint 0 and charger_enable 0 on that edge; fault_count increments, saturating at 8'hFF.
REQ-024 FAULT: holdoff counter counts consecutive non-critical cycles, clears on GRID_CRITICAL; at HOLDOFF_CYCLES -> IDLE.
REQ-025 In RAMP, CHARGE, DERATE, ev_connected or charge_request low -> IDLE, setpoint 0 next edge; in FAULT these inputs are ignored.
REQ-026 Priority on simultaneous events: GRID_CRITICAL > ev/request loss > GRID_UNSTABLE > ramp completion.
REQ-027 charger_enable SHALL be 1 exactly in RAMP, CHARGE, DERATE; setpoint SHALL be 0 in IDLE and FAULT.
REQ-028 current_request changes mid-charge SHALL retarget without leaving CHARGE; increases re-ramp at RAMP_STEP.

Reset
REQ-029 reset_n low SHALL asynchronously force IDLE, charge_setpoint 0, charger_enable 0, fault_count 0, both internal counters 0.
REQ-030 Reset asserted mid-operation SHALL abort immediately; after release the block starts from IDLE and needs a fresh start condition.

Structure
REQ-031 charge_state_t and default constants (RAMP_STEP, V_START_ADC) SHALL live in the shared sc_include package alongside grid_state_t.
REQ-032 One sub-module, charge_ramp_limiter (combinational slew/saturate of setpoint toward target), SHALL be used; FSM and counters stay in the top.

Verification
REQ-033 NORMAL, V=3000, request=100 -> RAMP, setpoint 32,64,96,100, CHARGE on the cycle setpoint=100, enable=1.
REQ-034 CHARGE at 1000, grid goes UNSTABLE one cycle -> DERATE, setpoint 500 next edge; 256 NORMAL cycles later -> RAMP toward 1000.
REQ-035 CHARGE, GRID_CRITICAL one cycle -> FAULT, setpoint 0, enable 0, fault_count 1; IDLE after 1024 clean cycles; CRITICAL at cycle 500 restarts count.
REQ-036 UNSTABLE and ev_connected low in the same cycle -> IDLE (not DERATE); CRITICAL and ev loss together -> FAULT.
REQ-037 request=16'hFFF0, RAMP_STEP=32 -> setpoint saturates at 16'hFFF0, no wrap; V=2799 in IDLE -> stays IDLE.
REQ-038 reset_n pulsed low asynchronously during RAMP -> outputs 0 immediately, IDLE after release, fault_count 0.

Source files
------------

// File: rtl/sc_include.sv
// Shared types and default constants for the charger control slice.
package sc_include;

    typedef enum logic [1:0] {
        GRID_NORMAL   = 2'd0,
        GRID_UNSTABLE = 2'd1,
        GRID_CRITICAL = 2'd2
    } grid_state_t;

    typedef enum logic [2:0] {
        CS_IDLE   = 3'd0,
        CS_RAMP   = 3'd1,
        CS_CHARGE = 3'd2,
        CS_DERATE = 3'd3,
        CS_FAULT  = 3'd4
    } charge_state_t;

    localparam logic [15:0] DEF_RAMP_STEP      = 16'd32;
    localparam logic [15:0] DEF_V_START_ADC    = 16'd2800;
    localparam int          DEF_STABLE_CYCLES  = 256;
    localparam int          DEF_HOLDOFF_CYCLES = 1024;

    // Current target for a grid condition: full request, half request, or nothing.
    // The unused encoding is treated like a critical grid.
    function automatic logic [15:0] grid_target(input grid_state_t grid, input logic [15:0] request);
        logic [15:0] t;
        case (grid)
            GRID_NORMAL:   t = request;
            GRID_UNSTABLE: t = request >> 1;
            default:       t = 16'd0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/charge_ramp_limiter.sv
// Combinational slew limiter: moves the setpoint toward the target, rising by at
// most RAMP_STEP per evaluation and falling straight to the target.
module charge_ramp_limiter
    import sc_include::*;
#(
    parameter logic [15:0] RAMP_STEP = DEF_RAMP_STEP
) (
    input  logic [15:0] setpoint,
    input  logic [15:0] target,
    output logic [15:0] next_setpoint,
    output logic        at_target
);

    logic [15:0] diff;
    logic [15:0] inc;
    logic [16:0] sum;

    // Slew up with a 17-bit sum so the result can never wrap past 16'hFFFF.
    always_comb begin
        diff          = 16'd0;
        inc           = 16'd0;
        sum           = 17'd0;
        next_setpoint = setpoint;
        if (target <= setpoint) begin
            next_setpoint = target;
        end else begin
            diff = target - setpoint;
            inc  = (diff > RAMP_STEP) ? RAMP_STEP : diff;
            sum  = {1'b0, setpoint} + {1'b0, inc};
            next_setpoint = sum[16] ? 16'hFFFF : sum[15:0];
        end
        at_target = (next_setpoint == target);
    end

endmodule

// File: rtl/charge_rate_controller.sv
// EV charge rate controller: sequences the power stage setpoint against grid
// health, with derating on an unstable grid and a holdoff after faults.
//
//   state  | meaning
//   IDLE   | no charge, setpoint 0, waiting for plug + request + healthy grid
//   RAMP   | setpoint slewing up toward target
//   CHARGE | setpoint tracking target (slewed up, immediate down)
//   DERATE | setpoint capped at half request until grid is stable long enough
//   FAULT  | power stage off until grid has been non-critical for the holdoff
module charge_rate_controller
    import sc_include::*;
#(
    parameter logic [15:0] RAMP_STEP      = DEF_RAMP_STEP,
    parameter int          STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int          HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
    parameter logic [15:0] V_START_ADC    = DEF_V_START_ADC
) (
    input  logic          clk,
    input  logic          reset_n,
    input  grid_state_t   grid_state,
    input  logic [15:0]   measured_voltage,
    input  logic          ev_connected,
    input  logic          charge_request,
    input  logic [15:0]   current_request,
    output logic [15:0]   charge_setpoint,
    output logic          charger_enable,
    output charge_state_t charge_state,
    output logic [7:0]    fault_count
);

    localparam int STABLE_W  = $clog2(STABLE_CYCLES + 1);
    localparam int HOLDOFF_W = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [STABLE_W-1:0]  STABLE_LAST  = STABLE_W'(STABLE_CYCLES - 1);
    localparam logic [HOLDOFF_W-1:0] HOLDOFF_LAST = HOLDOFF_W'(HOLDOFF_CYCLES - 1);

    logic [STABLE_W-1:0]  stable_cnt;
    logic [HOLDOFF_W-1:0] holdoff_cnt;

    charge_state_t        state_nxt;
    logic [15:0]          setpoint_nxt;
    logic                 enable_nxt;
    logic [7:0]           fault_count_nxt;
    logic [STABLE_W-1:0]  stable_nxt;
    logic [HOLDOFF_W-1:0] holdoff_nxt;

    logic [15:0] target;
    logic [15:0] half_request;
    logic [15:0] slewed_setpoint;
    logic        slew_done;
    logic        grid_normal;
    logic        grid_unstable;
    logic        grid_critical;
    logic        link_ok;
    logic        start_ok;

    assign target        = grid_target(grid_state, current_request);
    assign half_request  = current_request >> 1;
    assign grid_normal   = (grid_state == GRID_NORMAL);
    assign grid_unstable = (grid_state == GRID_UNSTABLE);
    assign grid_critical = !grid_normal && !grid_unstable;
    assign link_ok       = ev_connected && charge_request;
    assign start_ok      = link_ok && grid_normal && (measured_voltage >= V_START_ADC);

    charge_ramp_limiter #(
        .RAMP_STEP (RAMP_STEP)
    ) u_limiter (
        .setpoint      (charge_setpoint),
        .target        (target),
        .next_setpoint (slewed_setpoint),
        .at_target     (slew_done)
    );

    // Next-state and next-output logic; critical grid overrides everything,
    // then loss of vehicle/request, then grid instability, then slewing.
    always_comb begin
        state_nxt       = charge_state;
        setpoint_nxt    = charge_setpoint;
        fault_count_nxt = fault_count;
        stable_nxt      = stable_cnt;
        holdoff_nxt     = holdoff_cnt;

        if (grid_critical) begin
            state_nxt    = CS_FAULT;
            setpoint_nxt = 16'd0;
            stable_nxt   = '0;
            holdoff_nxt  = '0;
            if ((charge_state != CS_FAULT) && (fault_count != 8'hFF)) begin
                fault_count_nxt = fault_count + 8'd1;
            end
        end else begin
            case (charge_state)
                CS_IDLE: begin
                    setpoint_nxt = 16'd0;
                    if (start_ok) begin
                        state_nxt = CS_RAMP;
                    end
                end
                CS_RAMP, CS_CHARGE, CS_DERATE: begin
                    if (!link_ok) begin
                        state_nxt    = CS_IDLE;
                        setpoint_nxt = 16'd0;
                        stable_nxt   = '0;
                    end else if (grid_unstable) begin
                        state_nxt    = CS_DERATE;
                        stable_nxt   = '0;
                        setpoint_nxt = (charge_setpoint > half_request) ? half_request : charge_setpoint;
                    end else if (charge_state == CS_DERATE) begin
                        // Hold the derated level while counting stable cycles.
                        setpoint_nxt = (charge_setpoint > half_request) ? half_request : charge_setpoint;
                        if (stable_cnt == STABLE_LAST) begin
                            state_nxt  = CS_RAMP;
                            stable_nxt = '0;
                        end else begin
                            stable_nxt = stable_cnt + 1'b1;
                        end
                    end else begin
                        setpoint_nxt = slewed_setpoint;
                        if ((charge_state == CS_RAMP) && slew_done) begin
                            state_nxt = CS_CHARGE;
                        end
                    end
                end
                CS_FAULT: begin
                    setpoint_nxt = 16'd0;
                    if (holdoff_cnt == HOLDOFF_LAST) begin
                        state_nxt   = CS_IDLE;
                        holdoff_nxt = '0;
                    end else begin
                        holdoff_nxt = holdoff_cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt    = CS_IDLE;
                    setpoint_nxt = 16'd0;
                    stable_nxt   = '0;
                    holdoff_nxt  = '0;
                end
            endcase
        end

        enable_nxt = (state_nxt == CS_RAMP) || (state_nxt == CS_CHARGE) || (state_nxt == CS_DERATE);
    end

    // State, outputs and counters; reset aborts any charge immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            charge_state    <= CS_IDLE;
            charge_setpoint <= 16'd0;
            charger_enable  <= 1'b0;
            fault_count     <= 8'd0;
            stable_cnt      <= '0;
            holdoff_cnt     <= '0;
        end else begin
            charge_state    <= state_nxt;
            charge_setpoint <= setpoint_nxt;
            charger_enable  <= enable_nxt;
            fault_count     <= fault_count_nxt;
            stable_cnt      <= stable_nxt;
            holdoff_cnt     <= holdoff_nxt;
        end
    end

endmodule

// File: tb/tb_charge_rate_controller.sv
// Directed bench for charge_rate_controller with hand-computed expectations.
module tb_charge_rate_controller;
    import sc_include::*;

    logic          clk = 1'b0;
    logic          reset_n;
    grid_state_t   grid_state;
    logic [15:0]   measured_voltage;
    logic          ev_connected;
    logic          charge_request;
    logic [15:0]   current_request;
    logic [15:0]   charge_setpoint;
    logic          charger_enable;
    charge_state_t charge_state;
    logic [7:0]    fault_count;

    int n_cmp = 0;
    int n_err = 0;

    charge_rate_controller dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .grid_state       (grid_state),
        .measured_voltage (measured_voltage),
        .ev_connected     (ev_connected),
        .charge_request   (charge_request),
        .current_request  (current_request),
        .charge_setpoint  (charge_setpoint),
        .charger_enable   (charger_enable),
        .charge_state     (charge_state),
        .fault_count      (fault_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; grid_state = GRID_NORMAL; measured_voltage = 16'd0;
        ev_connected = 1'b0; charge_request = 1'b0; current_request = 16'd0;
        #22;
        n_cmp++; if (charge_state !== CS_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", charge_state, CS_IDLE); end
        n_cmp++; if (charge_setpoint !== 16'd0) begin n_err++; $display("FAIL reset_setpoint: got %0d want 0", charge_setpoint); end
        n_cmp++; if (charger_enable !== 1'b0) begin n_err++; $display("FAIL reset_enable: got %0b want 0", charger_enable); end
        n_cmp++; if (fault_count !== 8'd0) begin n_err++; $display("FAIL reset_fault_count: got %0d want 0", fault_count); end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_start_voltage();
        ev_connected = 1'b1; charge_request = 1'b1; current_request = 16'd100;
        measured_voltage = 16'd2799;
        repeat (3) tick();
        n_cmp++; if (charge_state !== CS_IDLE) begin n_err++; $display("FAIL low_v_state: got %0d want %0d", charge_state, CS_IDLE); end
        n_cmp++; if (charger_enable !== 1'b0) begin n_err++; $display("FAIL low_v_enable: got %0b want 0", charger_enable); end
        measured_voltage = 16'd2800;
        tick();
        n_cmp++; if (charge_state !== CS_RAMP) begin n_err++; $display("FAIL v_boundary_state: got %0d want %0d", charge_state, CS_RAMP); end
        charge_request = 1'b0;
        tick();
        n_cmp++; if (charge_state !== CS_IDLE) begin n_err++; $display("FAIL req_loss_state: got %0d want %0d", charge_state, CS_IDLE); end
        n_cmp++; if (charge_setpoint !== 16'd0) begin n_err++; $display("FAIL req_loss_setpoint: got %0d want 0", charge_setpoint); end
    endtask

    task automatic test_ramp();
        logic [15:0] exp_sp [4] = '{16'd32, 16'd64, 16'd96, 16'd100};
        charge_request = 1'b1; measured_voltage = 16'd3000; current_request = 16'd100;
        tick();
        n_cmp++; if (charge_state !== CS_RAMP) begin n_err++; $display("FAIL ramp_entry_state: got %0d want %0d", charge_state, CS_RAMP); end
        n_cmp++; if (charger_enable !== 1'b1) begin n_err++; $display("FAIL ramp_entry_enable: got %0b want 1", charger_enable); end
        n_cmp++; if (charge_setpoint !== 16'd0) begin n_err++; $display("FAIL ramp_entry_setpoint: got %0d want 0", charge_setpoint); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (charge_setpoint !== exp_sp[i]) begin n_err++; $display("FAIL ramp_setpoint[%0d]: got %0d want %0d", i, charge_setpoint, exp_sp[i]); end
            n_cmp++; if (charge_state !== ((i == 3) ? CS_CHARGE : CS_RAMP)) begin n_err++; $display("FAIL ramp_state[%0d]: got %0d", i, charge_state); end
        end
    endtask

    task automatic test_retarget();
        current_request = 16'd1000;
        tick();
        n_cmp++; if (charge_setpoint !== 16'd132) begin n_err++; $display("FAIL retarget_up: got %0d want 132", charge_setpoint); end
        n_cmp++; if (charge_state !== CS_CHARGE) begin n_err++; $display("FAIL retarget_state: got %0d want %0d", charge_state, CS_CHARGE); end
        repeat (28) tick();
        n_cmp++; if (charge_setpoint !== 16'd1000) begin n_err++; $display("FAIL retarget_reach: got %0d want 1000", charge_setpoint); end
        current_request = 16'd40;
        tick();
        n_cmp++; if (charge_setpoint !== 16'd40) begin n_err++; $display("FAIL retarget_down: got %0d want 40", charge_setpoint); end
        current_request = 16'd1000;
        repeat (30) tick();
        n_cmp++; if (charge_setpoint !== 16'd1000) begin n_err++; $display("FAIL retarget_reup: got %0d want 1000", charge_setpoint); end
    endtask

    task automatic test_derate();
        grid_state = GRID_UNSTABLE;
        tick();
        grid_state = GRID_NORMAL;
        n_cmp++; if (charge_state !== CS_DERATE) begin n_err++; $display("FAIL derate_state: got %0d want %0d", charge_state, CS_DERATE); end
        n_cmp++; if (charge_setpoint !== 16'd500) begin n_err++; $display("FAIL derate_setpoint: got %0d want 500", charge_setpoint); end
        n_cmp++; if (charger_enable !== 1'b1) begin n_err++; $display("FAIL derate_enable: got %0b want 1", charger_enable); end
        repeat (255) tick();
        n_cmp++; if (charge_state !== CS_DERATE) begin n_err++; $display("FAIL derate_hold_255: got %0d want %0d", charge_state, CS_DERATE); end
        n_cmp++; if (charge_setpoint !== 16'd500) begin n_err++; $display("FAIL derate_hold_sp: got %0d want 500", charge_setpoint); end
        tick();
        n_cmp++; if (charge_state !== CS_RAMP) begin n_err++; $display("FAIL derate_exit_256: got %0d want %0d", charge_state, CS_RAMP); end
        tick();
        n_cmp++; if (charge_setpoint !== 16'd532) begin n_err++; $display("FAIL derate_reramp: got %0d want 532", charge_setpoint); end
        repeat (14) tick();
        n_cmp++; if (charge_setpoint !== 16'd980 || charge_state !== CS_RAMP) begin n_err++; $display("FAIL reramp_mid: got %0d/%0d want 980/%0d", charge_setpoint, charge_state, CS_RAMP); end
        tick();
        n_cmp++; if (charge_setpoint !== 16'd1000 || charge_state !== CS_CHARGE) begin n_err++; $display("FAIL reramp_done: got %0d/%0d want 1000/%0d", charge_setpoint, charge_state, CS_CHARGE); end
    endtask

    task automatic test_fault();
        grid_state = GRID_CRITICAL;
        tick();
        grid_state = GRID_NORMAL;
        n_cmp++; if (charge_state !== CS_FAULT) begin n_err++; $display("FAIL fault_state: got %0d want %0d", charge_state, CS_FAULT); end
        n_cmp++; if (charge_setpoint !== 16'd0) begin n_err++; $display("FAIL fault_setpoint: got %0d want 0", charge_setpoint); end
        n_cmp++; if (charger_enable !== 1'b0) begin n_err++; $display("FAIL fault_enable: got %0b want 0", charger_enable); end
        n_cmp++; if (fault_count !== 8'd1) begin n_err++; $display("FAIL fault_count_1: got %0d want 1", fault_count); end
        repeat (499) tick();
        grid_state = GRID_CRITICAL;
        tick();
        grid_state = GRID_NORMAL;
        n_cmp++; if (charge_state !== CS_FAULT || fault_count !== 8'd1) begin n_err++; $display("FAIL fault_recrit: got %0d/%0d want %0d/1", charge_state, fault_count, CS_FAULT); end
        repeat (1023) tick();
        n_cmp++; if (charge_state !== CS_FAULT) begin n_err++; $display("FAIL holdoff_1023: got %0d want %0d", charge_state, CS_FAULT); end
        tick();
        n_cmp++; if (charge_state !== CS_IDLE) begin n_err++; $display("FAIL holdoff_1024: got %0d want %0d", charge_state, CS_IDLE); end
        n_cmp++; if (charge_setpoint !== 16'd0 || charger_enable !== 1'b0) begin n_err++; $display("FAIL holdoff_outputs: got %0d/%0b want 0/0", charge_setpoint, charger_enable); end
    endtask

    task automatic test_priority();
        tick();
        n_cmp++; if (charge_state !== CS_RAMP) begin n_err++; $display("FAIL prio_start: got %0d want %0d", charge_state, CS_RAMP); end
        grid_state = GRID_UNSTABLE; ev_connected = 1'b0;
        tick();
        n_cmp++; if (charge_state !== CS_IDLE) begin n_err++; $display("FAIL prio_unstable_evloss: got %0d want %0d", charge_state, CS_IDLE); end
        n_cmp++; if (charger_enable !== 1'b0) begin n_err++; $display("FAIL prio_unstable_enable: got %0b want 0", charger_enable); end
        grid_state = GRID_NORMAL; ev_connected = 1'b1;
        tick();
        tick();
        n_cmp++; if (charge_setpoint !== 16'd32) begin n_err++; $display("FAIL prio_ramp_sp: got %0d want 32", charge_setpoint); end
        grid_state = GRID_CRITICAL; ev_connected = 1'b0;
        tick();
        grid_state = GRID_NORMAL; ev_connected = 1'b1;
        n_cmp++; if (charge_state !== CS_FAULT) begin n_err++; $display("FAIL prio_crit_evloss: got %0d want %0d", charge_state, CS_FAULT); end
        n_cmp++; if (fault_count !== 8'd2) begin n_err++; $display("FAIL fault_count_2: got %0d want 2", fault_count); end
        repeat (1024) tick();
        n_cmp++; if (charge_state !== CS_IDLE) begin n_err++; $display("FAIL prio_holdoff_exit: got %0d want %0d", charge_state, CS_IDLE); end
    endtask

    task automatic test_saturate();
        logic [16:0] sum;
        logic [15:0] exp_sp;
        current_request = 16'hFFF0;
        tick();
        n_cmp++; if (charge_state !== CS_RAMP) begin n_err++; $display("FAIL sat_entry: got %0d want %0d", charge_state, CS_RAMP); end
        exp_sp = 16'd0;
        for (int i = 0; i < 2048; i++) begin
            tick();
            sum    = {1'b0, exp_sp} + 17'd32;
            exp_sp = (sum > 17'h0FFF0) ? 16'hFFF0 : sum[15:0];
            n_cmp++; if (charge_setpoint !== exp_sp) begin n_err++; $display("FAIL sat_ramp[%0d]: got %0h want %0h", i, charge_setpoint, exp_sp); end
        end
        n_cmp++; if (charge_state !== CS_CHARGE) begin n_err++; $display("FAIL sat_charge: got %0d want %0d", charge_state, CS_CHARGE); end
        tick();
        n_cmp++; if (charge_setpoint !== 16'hFFF0) begin n_err++; $display("FAIL sat_hold: got %0h want fff0", charge_setpoint); end
    endtask

    task automatic test_async_reset();
        charge_request = 1'b0;
        tick();
        current_request = 16'd100; charge_request = 1'b1;
        tick();
        tick();
        n_cmp++; if (charge_state !== CS_RAMP || charge_setpoint !== 16'd32) begin n_err++; $display("FAIL rst_pre: got %0d/%0d want %0d/32", charge_state, charge_setpoint, CS_RAMP); end
        #3;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (charge_state !== CS_IDLE) begin n_err++; $display("FAIL async_rst_state: got %0d want %0d", charge_state, CS_IDLE); end
        n_cmp++; if (charge_setpoint !== 16'd0 || charger_enable !== 1'b0) begin n_err++; $display("FAIL async_rst_outputs: got %0d/%0b want 0/0", charge_setpoint, charger_enable); end
        n_cmp++; if (fault_count !== 8'd0) begin n_err++; $display("FAIL async_rst_fault_count: got %0d want 0", fault_count); end
        charge_request = 1'b0;
        #3;
        reset_n = 1'b1;
        tick();
        n_cmp++; if (charge_state !== CS_IDLE) begin n_err++; $display("FAIL post_rst_idle: got %0d want %0d", charge_state, CS_IDLE); end
        charge_request = 1'b1;
        tick();
        tick();
        n_cmp++; if (charge_state !== CS_RAMP || charge_setpoint !== 16'd32) begin n_err++; $display("FAIL post_rst_ramp: got %0d/%0d want %0d/32", charge_state, charge_setpoint, CS_RAMP); end
    endtask

    initial begin
        test_reset();
        test_start_voltage();
        test_ramp();
        test_retarget();
        test_derate();
        test_fault();
        test_priority();
        test_saturate();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
